// File: rtl/serial_adder_pkg.sv
// Shared definitions for the 32-bit serial adder: controller state encoding
// and the default word width used by the operand and result registers.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/dff.sv
// Team register cell: W-bit D flip-flop with synchronous active-low reset
// and a load enable.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit right-shift register: serial bits enter at the MSB and move
// toward bit 0; a synchronous clear takes priority over shifting.
module sipo_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d;

  assign d = clr ? '0 : {serial_in, q[WIDTH-1:1]};

  dff #(.W(WIDTH)) u_reg (
    .clk (clk),
    .rst (rst),
    .en  (clr | shift_en),
    .d   (d),
    .q   (q)
  );

endmodule

// File: rtl/sipo_capture.sv
// Result-side capture of the serial adder: collects WIDTH sum bits LSB-first,
// latches the final carry and flags completion with done / out_valid.
module sipo_capture
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shift,
  input  logic             serial_in,
  input  logic             carry_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             carry_out,
  output logic [CNT_W-1:0] bit_count,
  output logic             busy,
  output logic             done,
  output logic             out_valid
);

  state_t state, state_next;
  logic   take_bit;
  logic   last_bit;

  // start wins over a coincident shift, so the bit offered with it is dropped
  assign take_bit = (state == COLLECT) && shift && !start;
  assign last_bit = take_bit && (bit_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: assign the default first so every path writes state_next and no
  // latch is inferred.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = COLLECT;
    end else if (last_bit) begin
      state_next = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_count <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= last_bit;
      if (start) begin
        bit_count <= '0;
        carry_out <= 1'b0;
      end else if (take_bit) begin
        bit_count <= bit_count + CNT_W'(1);
        if (last_bit) begin
          carry_out <= carry_in;
        end
      end
    end
  end

  // Decoded from the state register only, so no input reaches them directly.
  assign busy = (state == COLLECT);
  assign done = (state == DONE);

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .shift_en  (take_bit),
    .serial_in (serial_in),
    .q         (parallel_out)
  );

endmodule

// File: tb/tb_sipo_capture.sv
// Directed bench for sipo_capture: full words, gaps, restarts, DONE hold,
// start/shift collision and mid-word reset, with hand-computed expectations.
module tb_sipo_capture;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             shift = 1'b0;
  logic             serial_in = 1'b0;
  logic             carry_in = 1'b0;
  logic [WIDTH-1:0] parallel_out;
  logic             carry_out;
  logic [CNT_W-1:0] bit_count;
  logic             busy;
  logic             done;
  logic             out_valid;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  sipo_capture #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .shift        (shift),
    .serial_in    (serial_in),
    .carry_in     (carry_in),
    .parallel_out (parallel_out),
    .carry_out    (carry_out),
    .bit_count    (bit_count),
    .busy         (busy),
    .done         (done),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) pulses++;
  endtask

  task automatic idle_cycles(input int n);
    shift = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b, input logic c);
    shift     = 1'b1;
    serial_in = b;
    carry_in  = c;
    tick();
    shift     = 1'b0;
    carry_in  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    chk("reset parallel_out", 64'(parallel_out), 64'h0);
    chk("reset carry_out", 64'(carry_out), 64'h0);
    chk("reset bit_count", 64'(bit_count), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset out_valid", 64'(out_valid), 64'h0);
    rst = 1'b1;
  endtask

  task automatic test_full_word();
    logic [31:0] w;
    int early;
    w = 32'hA5A51234;
    early = 0;
    do_start();
    chk("start busy", 64'(busy), 64'h1);
    chk("start bit_count", 64'(bit_count), 64'h0);
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      send_bit(w[i], i == 31);
      if (i < 31 && (out_valid || done)) early++;
    end
    chk("full early valid/done", 64'(early), 64'h0);
    chk("full out_valid", 64'(out_valid), 64'h1);
    chk("full parallel_out", 64'(parallel_out), 64'hA5A51234);
    chk("full carry_out", 64'(carry_out), 64'h1);
    chk("full bit_count", 64'(bit_count), 64'd32);
    chk("full done", 64'(done), 64'h1);
    chk("full busy", 64'(busy), 64'h0);
    idle_cycles(1);
    chk("full valid drops", 64'(out_valid), 64'h0);
    chk("full pulse count", 64'(pulses), 64'h1);
  endtask

  task automatic test_done_hold();
    pulses = 0;
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0);
    chk("hold parallel_out", 64'(parallel_out), 64'hA5A51234);
    chk("hold carry_out", 64'(carry_out), 64'h1);
    chk("hold done", 64'(done), 64'h1);
    chk("hold bit_count", 64'(bit_count), 64'd32);
    chk("hold pulses", 64'(pulses), 64'h0);
  endtask

  task automatic test_gaps();
    logic [31:0] w;
    w = 32'h0000FFFF;
    do_start();
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      // carry_in high on every bit except the last must not be latched
      send_bit(w[i], i != 31);
      if (i == 5 || i == 20) begin
        idle_cycles(3);
        chk($sformatf("gap bit_count after %0d", i), 64'(bit_count), 64'(i + 1));
        chk($sformatf("gap busy after %0d", i), 64'(busy), 64'h1);
      end
      if (i == 30) chk("gap not done at 31", 64'(done), 64'h0);
    end
    chk("gap parallel_out", 64'(parallel_out), 64'h0000FFFF);
    chk("gap carry_out", 64'(carry_out), 64'h0);
    chk("gap done", 64'(done), 64'h1);
    chk("gap pulses", 64'(pulses), 64'h1);
  endtask

  task automatic test_restart();
    logic [31:0] w;
    w = 32'h80000001;
    do_start();
    pulses = 0;
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    chk("restart partial count", 64'(bit_count), 64'd10);
    do_start();
    chk("restart bit_count", 64'(bit_count), 64'h0);
    chk("restart parallel_out", 64'(parallel_out), 64'h0);
    chk("restart busy", 64'(busy), 64'h1);
    for (int i = 0; i < 32; i++) send_bit(w[i], 1'b0);
    chk("restart word", 64'(parallel_out), 64'h80000001);
    chk("restart done", 64'(done), 64'h1);
    idle_cycles(2);
    chk("restart pulses", 64'(pulses), 64'h1);
  endtask

  task automatic test_start_wins();
    start     = 1'b1;
    shift     = 1'b1;
    serial_in = 1'b1;
    tick();
    start = 1'b0;
    shift = 1'b0;
    chk("collide bit_count", 64'(bit_count), 64'h0);
    chk("collide parallel_out", 64'(parallel_out), 64'h0);
    chk("collide done", 64'(done), 64'h0);
    for (int i = 0; i < 32; i++) send_bit(1'b0, 1'b0);
    chk("collide word", 64'(parallel_out), 64'h0);
    chk("collide final done", 64'(done), 64'h1);
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 17; i++) send_bit(1'b1, 1'b1);
    chk("mid count", 64'(bit_count), 64'd17);
    rst = 1'b0;
    shift = 1'b1;
    serial_in = 1'b1;
    tick();
    shift = 1'b0;
    chk("midrst parallel_out", 64'(parallel_out), 64'h0);
    chk("midrst bit_count", 64'(bit_count), 64'h0);
    chk("midrst busy", 64'(busy), 64'h0);
    chk("midrst done", 64'(done), 64'h0);
    chk("midrst carry_out", 64'(carry_out), 64'h0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    chk("idle parallel_out", 64'(parallel_out), 64'h0);
    chk("idle bit_count", 64'(bit_count), 64'h0);
    chk("idle busy", 64'(busy), 64'h0);
    chk("idle pulses", 64'(pulses), 64'h0);
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_done_hold();
    test_gaps();
    test_restart();
    test_start_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_capture.md
Name: sipo_capture

Overview:
- Serial-in/parallel-out capture block at the result end of the 32-bit serial adder.
- Receives the serial sum LSB-first, one bit per qualified shift, and reassembles it into a WIDTH-bit parallel word.
- Latches the final carry and signals completion with a held done level and a one-cycle valid pulse.
- Mirror of the operand-side parallel-load/serial-shift register.

Parameters:
- WIDTH, 32, number of bits collected per word; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the bit counter (derived, not overridden).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- start  input  1  clears the capture register and counter, arms collection.
- shift  input  1  qualifies serial_in as a valid bit this cycle.
- serial_in  input  1  serial sum bit, LSB first.
- carry_in  input  1  adder carry; sampled together with the final (WIDTH-th) bit.
- parallel_out  output  WIDTH  assembled word; bit 0 = first bit received.
- carry_out  output  1  carry latched on the final bit.
- bit_count  output  CNT_W  bits received since the last start (0..WIDTH).
- busy  output  1  high in COLLECT.
- done  output  1  high in DONE; held until the next start or reset.
- out_valid  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - parallel_out=0, carry_out=0, bit_count=0, busy=0, done=0, out_valid=0.
  - Reset overrides all other inputs, including mid-collection; any partial word is discarded.
- States:
  - IDLE: shift ignored; start -> COLLECT.
  - COLLECT: counts and shifts; goes to DONE on the WIDTH-th qualified shift.
  - DONE: shift ignored; start -> COLLECT.
- Start, in any state:
  - Next cycle: parallel_out=0, bit_count=0, carry_out=0, busy=1, done=0.
  - A shift asserted in the same cycle as start is dropped; start wins.
  - Start while in COLLECT restarts collection from zero.
- Shift in COLLECT without start, at the clock edge:
  - parallel_out <= {serial_in, parallel_out[WIDTH-1:1]}, so bits enter at the MSB and move right.
  - After WIDTH shifts, the first bit received sits at bit 0.
  - bit_count increments by 1.
- Final shift (bit_count==WIDTH-1 and shift):
  - Shift as above; carry_out <= carry_in; bit_count becomes WIDTH.
  - Next cycle: state DONE, busy=0, done=1, out_valid=1.
  - Latency: out_valid is visible in the cycle after the edge that sampled the last bit.
- Outside the final shift:
  - out_valid is 0 in every other cycle, including while DONE is held.
- Shift gaps: shift may drop for any number of cycles in COLLECT; state and counter hold.
- DONE hold: parallel_out and carry_out stay stable until start or reset; stray shifts never corrupt a completed word.
- Counter range: bit_count never exceeds WIDTH and never wraps.
- Registers: all outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package serial_adder_pkg:
  - State enum (IDLE, COLLECT, DONE) as a 2-bit typedef.
  - Default WIDTH constant (32), shared with the operand registers and the adder controller.
- One natural sub-module, sipo_shift_reg:
  - WIDTH-bit right-shift register with sync clear and shift-enable, built from the team's dff cell.
  - sipo_capture holds the FSM, bit counter, carry latch and pulse generation.

Test Plan:
1. Reset, then start, then 32 consecutive shifts of 0xA5A51234 LSB-first with carry_in=1 on bit 31 -> parallel_out=0xA5A51234, carry_out=1, bit_count=32, done=1, out_valid high exactly one cycle, in the cycle after the 32nd shift.
2. Start, then 0x0000FFFF sent with shift deasserted for 3 cycles after bits 5 and 20 -> parallel_out=0x0000FFFF, done after exactly 32 qualified shifts, bit_count holds during the gaps.
3. Start, 10 bits of ones, then start again, then 32 bits of 0x80000001 -> parallel_out=0x80000001, no residual ones, bit_count restarted at 0, only one out_valid pulse.
4. After test 1 completes, 8 shifts with serial_in=0 -> parallel_out stays 0xA5A51234, done stays 1, out_valid stays 0.
5. Start asserted in the same cycle as shift with serial_in=1, then 32 shifts of 0x00000000 -> parallel_out=0x00000000 (the simultaneous bit is dropped).
6. Assert rst=0 after 17 bits -> next cycle all outputs 0 and state IDLE; shifts in IDLE leave parallel_out=0 and bit_count=0.
